// File: rtl/ofifo_collector_pkg.sv
// Shared parameters and helpers for the output-side psum collector.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package ofifo_collector_pkg;

    // Default array geometry: one FIFO per MAC column.
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    // Ceiling log2 for address sizing. It is evaluated at elaboration, so the
    // bounded loop never reaches hardware.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    localparam int PTR_W = clog2(DEPTH) + 1;

endpackage

// File: rtl/ofifo_col.sv
// Single-column first-word-fall-through FIFO for one MAC column's psums.
// Latency: a word written at edge N appears on out after edge N; read is combinational.
// Backpressure: a write to a full column lands only when a pop happens in the same cycle.
module ofifo_col
    import ofifo_collector_pkg::*;
#(
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [bw-1:0] in,
    input  logic          wr,
    input  logic          rd,
    output logic [bw-1:0] out,
    output logic          o_empty,
    output logic          o_full
);

    localparam int AW = clog2(depth);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [bw-1:0] mem [depth];
    logic          wr_ok;

    // Equal pointers mean empty; same index with opposite wrap bits means full.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // The caller only asserts rd when every column holds data, so a pop in the
    // same cycle always frees the slot a full-column write needs.
    assign wr_ok = wr && (!o_full || rd);

    // Head of queue falls straight through from storage.
    assign out = mem[rd_ptr[AW-1:0]];

    // Pointer update; async reset discards all buffered words at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write; contents survive reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= in;
        end
    end

endmodule

// File: rtl/ofifo_collector.sv
// Re-aligns skewed per-column psums from the MAC array into full-width rows.
// Latency: a row is visible the cycle after its last column write; pop is combinational FWFT.
// Backpressure: rd pops only when all columns hold data; dropped writes/early reads set sticky flags.
module ofifo_collector
    import ofifo_collector_pkg::*;
#(
    parameter int col   = COL,
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic [col-1:0] col_empty;
    logic [col-1:0] col_full;
    logic           rd_acc;

    // Row status is a pure reduction over the column pointers.
    assign o_valid = &(~col_empty);
    assign o_full  = |col_full;
    assign o_empty = &col_empty;

    // One accepted rd pops every column together; partial pops never happen.
    assign rd_acc = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .bw    (bw),
            .depth (depth)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .in      (in[i*bw +: bw]),
            .wr      (wr[i]),
            .rd      (rd_acc),
            .out     (out[i*bw +: bw]),
            .o_empty (col_empty[i]),
            .o_full  (col_full[i])
        );
    end

    // Sticky error flags: a write lost to a full column, or a read with no full row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if ((|(wr & col_full)) && !rd_acc) begin
                o_overflow <= 1'b1;
            end
            if (rd && !o_valid) begin
                o_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofifo_collector.sv
// Scoreboard bench for ofifo_collector: stimulus pushes expected rows, a monitor checks pops.
// Latency: rows are compared on the negedge before the popping edge.
// Backpressure: flags are checked directly one time unit after each active edge.
module tb_ofifo_collector;

    localparam int COL = 8;
    localparam int BW  = 16;

    logic                clk;
    logic                reset;
    logic [COL*BW-1:0]   in;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [COL*BW-1:0]   out;
    logic                o_valid;
    logic                o_full;
    logic                o_empty;
    logic                o_overflow;
    logic                o_underflow;

    int checks = 0;
    int errors = 0;
    logic [COL*BW-1:0] exp_q [$];

    ofifo_collector #(
        .col   (COL),
        .bw    (BW),
        .depth (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [COL*BW-1:0] act, input logic [COL*BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Row whose column i holds base+i.
    function automatic logic [COL*BW-1:0] mk_row(input int base);
        logic [COL*BW-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            r[i*BW +: BW] = 16'(base + i);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed away from the clock edges.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1;
        chk("rst_empty", {127'd0, o_empty}, 128'd1);
        chk("rst_valid", {127'd0, o_valid}, 128'd0);
        chk("rst_ovf", {127'd0, o_overflow}, 128'd0);
        chk("rst_unf", {127'd0, o_underflow}, 128'd0);
        #1 reset = 1'b1;
    endtask

    // Monitor: every accepted pop must match the oldest expected row.
    always @(negedge clk) begin
        if (reset && rd && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got row %h expected no pop at %0t", out, $time);
            end else begin
                chk("row", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [COL*BW-1:0] row;
        reset = 1'b0;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;
        #1;

        // Held in reset: writes must be ignored.
        for (int j = 0; j < 4; j++) begin
            wr = (j % 2 == 0) ? 8'hFF : 8'h00;
            in = mk_row(16'h1111);
            step();
            chk("idle_empty", {127'd0, o_empty}, 128'd1);
            chk("idle_valid", {127'd0, o_valid}, 128'd0);
            chk("idle_full", {127'd0, o_full}, 128'd0);
            chk("idle_ovf", {127'd0, o_overflow}, 128'd0);
            chk("idle_unf", {127'd0, o_underflow}, 128'd0);
        end
        wr = '0;
        #1 reset = 1'b1;

        // Skewed fill: column i written in cycle i.
        for (int i = 0; i < COL; i++) begin
            in = '0;
            in[i*BW +: BW] = 16'h0100 + 16'(i);
            wr = 8'(1 << i);
            if (i == COL - 1) exp_q.push_back(mk_row(16'h0100));
            step();
            if (i < COL - 1) chk("skew_valid_lo", {127'd0, o_valid}, 128'd0);
            else             chk("skew_valid_hi", {127'd0, o_valid}, 128'd1);
        end
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("skew_empty", {127'd0, o_empty}, 128'd1);

        // Stream 200 rows with simultaneous write and read, wrapping pointers.
        wr = 8'hFF;
        in = mk_row(0);
        exp_q.push_back(in);
        step();
        for (int r = 1; r <= 200; r++) begin
            in = mk_row(r * 8);
            rd = 1'b1;
            exp_q.push_back(in);
            step();
        end
        wr = '0;
        step();
        rd = 1'b0;
        chk("stream_ovf", {127'd0, o_overflow}, 128'd0);
        chk("stream_unf", {127'd0, o_underflow}, 128'd0);
        chk("stream_empty", {127'd0, o_empty}, 128'd1);

        // Fill column 3 alone, then overflow it.
        for (int k = 0; k < 64; k++) begin
            in = '0;
            in[3*BW +: BW] = 16'h3000 + 16'(k);
            wr = 8'h08;
            step();
        end
        wr = '0;
        chk("c3_full", {127'd0, o_full}, 128'd1);
        chk("c3_valid", {127'd0, o_valid}, 128'd0);
        chk("c3_ovf_before", {127'd0, o_overflow}, 128'd0);
        in = '0;
        in[3*BW +: BW] = 16'hDEAD;
        wr = 8'h08;
        step();
        wr = '0;
        chk("c3_ovf_after", {127'd0, o_overflow}, 128'd1);
        chk("c3_full_after", {127'd0, o_full}, 128'd1);
        in = mk_row(16'hA000);
        wr = 8'hF7;
        step();
        wr = '0;
        chk("c3_row_valid", {127'd0, o_valid}, 128'd1);
        row = mk_row(16'hA000);
        row[3*BW +: BW] = 16'h3000;
        exp_q.push_back(row);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("c3_valid_after_pop", {127'd0, o_valid}, 128'd0);
        reset_pulse();

        // All columns full, then a same-cycle pop and push.
        for (int r = 0; r < 64; r++) begin
            in = mk_row(16'h5000 + r * 8);
            wr = 8'hFF;
            exp_q.push_back(in);
            step();
        end
        chk("allfull_full", {127'd0, o_full}, 128'd1);
        chk("allfull_valid", {127'd0, o_valid}, 128'd1);
        in = mk_row(16'h5000 + 64 * 8);
        exp_q.push_back(in);
        rd = 1'b1;
        step();
        wr = '0;
        chk("allfull_still_full", {127'd0, o_full}, 128'd1);
        chk("allfull_ovf", {127'd0, o_overflow}, 128'd0);
        for (int r = 0; r < 64; r++) begin
            step();
        end
        rd = 1'b0;
        chk("allfull_drained", {127'd0, o_empty}, 128'd1);
        reset_pulse();

        // Read with column 5 empty: no pop, underflow flag.
        in = mk_row(16'h6000);
        wr = 8'hDF;
        step();
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("unf_flag", {127'd0, o_underflow}, 128'd1);
        chk("unf_valid", {127'd0, o_valid}, 128'd0);
        chk("unf_not_empty", {127'd0, o_empty}, 128'd0);
        wr = 8'h20;
        step();
        wr = '0;
        chk("unf_row_valid", {127'd0, o_valid}, 128'd1);
        exp_q.push_back(mk_row(16'h6000));
        rd = 1'b1;
        step();
        rd = 1'b0;

        // Mid-stream reset discards buffered rows immediately.
        in = mk_row(16'h7000);
        wr = 8'hFF;
        step();
        step();
        wr = '0;
        chk("mid_not_empty", {127'd0, o_empty}, 128'd0);
        reset_pulse();
        step();
        chk("post_rst_empty", {127'd0, o_empty}, 128'd1);
        chk("post_rst_unf", {127'd0, o_underflow}, 128'd0);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
